lb_arbiter: RTL and testbench

//  Round-robin arbiter sharing one local-bus (LB) slave port (a CSR register map) between N_MST masters,
//  e.g. APB-to-LB bridge and a debug master. Sequences one transaction at a time: grant, drive, wait response.

---
 rtl/lb_arb_pkg.sv | 12 +
 rtl/lb_arb_rr_pick.sv | 28 ++
 rtl/lb_arbiter.sv | 159 +++++++++++++++
 tb/tb_lb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lb_arb_pkg.sv
// Shared definitions for the local-bus arbiter: FSM state encoding and default error read data.
package lb_arb_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WR   = 2'd1;
  localparam state_t ST_RD   = 2'd2;

  localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

endpackage

// File: rtl/lb_arb_rr_pick.sv
// Combinational round-robin pick: first requesting master at or after the pointer, wrapping.
module lb_arb_rr_pick #(
  parameter int N_MST = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_MST-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    idx  = '0;
    vld  = 1'b0;
    cand = '0;
    for (int i = N_MST - 1; i >= 0; i--) begin
      cand = PTR_W'((int'(ptr) + i) % N_MST);
      if (req[cand]) begin
        idx = cand;
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lb_arbiter.sv
// Round-robin arbiter sharing one local-bus slave between N_MST masters, one transaction at a time.
// Optional response timeout is enabled by defining LB_ARB_TIMEOUT_EN.
module lb_arbiter
  import lb_arb_pkg::*;
#(
  parameter int                N_MST       = 2,
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 32,
  parameter int                STRB_W      = DATA_W / 8,
  parameter int                TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA   = DATA_W'(ERR_RDATA_DEF)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MST-1:0]           m_wen,
  input  logic [N_MST*ADDR_W-1:0]    m_waddr,
  input  logic [N_MST*DATA_W-1:0]    m_wdata,
  input  logic [N_MST*STRB_W-1:0]    m_wstrb,
  output logic [N_MST-1:0]           m_wready,
  input  logic [N_MST-1:0]           m_ren,
  input  logic [N_MST*ADDR_W-1:0]    m_raddr,
  output logic [N_MST-1:0]           m_rvalid,
  output logic [DATA_W-1:0]          m_rdata,
  output logic                       lb_wen,
  output logic [ADDR_W-1:0]          lb_waddr,
  output logic [DATA_W-1:0]          lb_wdata,
  output logic [STRB_W-1:0]          lb_wstrb,
  input  logic                       lb_wready,
  output logic                       lb_ren,
  output logic [ADDR_W-1:0]          lb_raddr,
  input  logic                       lb_rvalid,
  input  logic [DATA_W-1:0]          lb_rdata,
  output logic [$clog2(N_MST)-1:0]   grant,
  output logic                       busy,
  output logic                       tmo_err
);

  localparam int PTR_W = $clog2(N_MST);

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [STRB_W-1:0]  wstrb_q, wstrb_d;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               tmo_hit;

  lb_arb_rr_pick #(
    .N_MST (N_MST),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (m_wen | m_ren),
    .ptr (ptr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

`ifdef LB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter sits at zero in IDLE so it is clear on the first WR/RD cycle.
  always_comb begin
    cnt_d = '0;
    if (state_q != ST_IDLE) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYC));
`else
  logic unused_tmo_cfg;

  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    m_wready = '0;
    m_rvalid = '0;
    m_rdata  = '0;
    tmo_err  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          if (m_wen[pick_idx]) begin
            state_d = ST_WR;
            addr_d  = m_waddr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_d = m_wdata[int'(pick_idx)*DATA_W +: DATA_W];
            wstrb_d = m_wstrb[int'(pick_idx)*STRB_W +: STRB_W];
          end else begin
            state_d = ST_RD;
            addr_d  = m_raddr[int'(pick_idx)*ADDR_W +: ADDR_W];
          end
        end
      end
      ST_WR: begin
        // A slave response in the expiry cycle takes precedence over the timeout.
        if (lb_wready || tmo_hit) begin
          m_wready[grant_q] = 1'b1;
          tmo_err           = !lb_wready;
          ptr_d             = PTR_W'((int'(grant_q) + 1) % N_MST);
          state_d           = ST_IDLE;
        end
      end
      ST_RD: begin
        if (lb_rvalid || tmo_hit) begin
          m_rvalid[grant_q] = 1'b1;
          m_rdata           = lb_rvalid ? lb_rdata : ERR_RDATA;
          tmo_err           = !lb_rvalid;
          ptr_d             = PTR_W'((int'(grant_q) + 1) % N_MST);
          state_d           = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign lb_wen   = (state_q == ST_WR);
  assign lb_ren   = (state_q == ST_RD);
  assign lb_waddr = addr_q;
  assign lb_raddr = addr_q;
  assign lb_wdata = wdata_q;
  assign lb_wstrb = wstrb_q;
  assign grant    = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed bench for lb_arbiter: write, read, contention, write-before-read, reset abort, optional timeout.
module tb_lb_arbiter;

  localparam int N_MST  = 2;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_MST-1:0]        m_wen;
  logic [N_MST*ADDR_W-1:0] m_waddr;
  logic [N_MST*DATA_W-1:0] m_wdata;
  logic [N_MST*STRB_W-1:0] m_wstrb;
  logic [N_MST-1:0]        m_wready;
  logic [N_MST-1:0]        m_ren;
  logic [N_MST*ADDR_W-1:0] m_raddr;
  logic [N_MST-1:0]        m_rvalid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    lb_wen;
  logic [ADDR_W-1:0]       lb_waddr;
  logic [DATA_W-1:0]       lb_wdata;
  logic [STRB_W-1:0]       lb_wstrb;
  logic                    lb_wready;
  logic                    lb_ren;
  logic [ADDR_W-1:0]       lb_raddr;
  logic                    lb_rvalid;
  logic [DATA_W-1:0]       lb_rdata;
  logic [0:0]              grant;
  logic                    busy;
  logic                    tmo_err;

  int checks = 0;
  int errors = 0;
  int acks [N_MST];

  lb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m_wen     (m_wen),
    .m_waddr   (m_waddr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wready  (m_wready),
    .m_ren     (m_ren),
    .m_raddr   (m_raddr),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .lb_wen    (lb_wen),
    .lb_waddr  (lb_waddr),
    .lb_wdata  (lb_wdata),
    .lb_wstrb  (lb_wstrb),
    .lb_wready (lb_wready),
    .lb_ren    (lb_ren),
    .lb_raddr  (lb_raddr),
    .lb_rvalid (lb_rvalid),
    .lb_rdata  (lb_rdata),
    .grant     (grant),
    .busy      (busy),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_g;
    rst = 1'b0;
    m_wen = '0; m_waddr = '0; m_wdata = '0; m_wstrb = '0;
    m_ren = '0; m_raddr = '0;
    lb_wready = 1'b0; lb_rvalid = 1'b0; lb_rdata = '0;
    acks[0] = 0; acks[1] = 0;

    cyc(2); #1;
    chk("rst_lb_wen", 64'(lb_wen), 64'd0);
    chk("rst_lb_ren", 64'(lb_ren), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m_rdata", 64'(m_rdata), 64'd0);
    chk("rst_lb_waddr", 64'(lb_waddr), 64'd0);
    chk("rst_tmo_err", 64'(tmo_err), 64'd0);
    rst = 1'b1;

    // Single write from master 0, slave answers on the third WR cycle.
    cyc();
    m_wen = 2'b01; m_waddr[15:0] = 16'h0040; m_wdata[31:0] = 32'h5; m_wstrb[3:0] = 4'hF;
    #1;
    chk("wr_latency_lb_wen", 64'(lb_wen), 64'd0);
    cyc(); #1;
    chk("wr_lb_wen", 64'(lb_wen), 64'd1);
    chk("wr_lb_waddr", 64'(lb_waddr), 64'h40);
    chk("wr_lb_wdata", 64'(lb_wdata), 64'h5);
    chk("wr_lb_wstrb", 64'(lb_wstrb), 64'hF);
    chk("wr_busy", 64'(busy), 64'd1);
    chk("wr_no_early_ack", 64'(m_wready), 64'd0);
    cyc(2);
    lb_wready = 1'b1;
    #1;
    chk("wr_m_wready", 64'(m_wready), 64'b01);
    chk("wr_lb_wen_held", 64'(lb_wen), 64'd1);
    cyc();
    m_wen = '0; lb_wready = 1'b0;
    #1;
    chk("wr_done_lb_wen", 64'(lb_wen), 64'd0);
    chk("wr_done_m_wready", 64'(m_wready), 64'd0);
    chk("wr_done_busy", 64'(busy), 64'd0);

    // Single read from master 1; lb_rdata is driven early to show m_rdata stays gated.
    m_ren = 2'b10; m_raddr[31:16] = 16'h0044; lb_rdata = 32'h00020010;
    cyc(); #1;
    chk("rd_lb_ren", 64'(lb_ren), 64'd1);
    chk("rd_lb_raddr", 64'(lb_raddr), 64'h44);
    chk("rd_grant", 64'(grant), 64'd1);
    chk("rd_lb_wen_low", 64'(lb_wen), 64'd0);
    chk("rd_rdata_gated", 64'(m_rdata), 64'd0);
    lb_wready = 1'b1;
    #1;
    chk("rd_ignores_wready", 64'(m_wready), 64'd0);
    cyc();
    lb_wready = 1'b0;
    #1;
    chk("rd_still_busy", 64'(lb_ren), 64'd1);
    lb_rvalid = 1'b1;
    #1;
    chk("rd_m_rvalid", 64'(m_rvalid), 64'b10);
    chk("rd_m_rdata", 64'(m_rdata), 64'h00020010);
    cyc();
    m_ren = '0; lb_rvalid = 1'b0;
    #1;
    chk("rd_done_lb_ren", 64'(lb_ren), 64'd0);
    chk("rd_done_m_rdata", 64'(m_rdata), 64'd0);
    chk("rd_done_grant", 64'(grant), 64'd1);

    // Both masters write continuously, four transactions each; grants must alternate.
    m_wen = 2'b11;
    m_waddr[15:0] = 16'h0100; m_waddr[31:16] = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      exp_g = i % 2;
      cyc(); #1;
      chk("rr_grant", 64'(grant), 64'(exp_g));
      chk("rr_lb_waddr", 64'(lb_waddr), 64'((exp_g == 0 ? 16'h0100 : 16'h0200) + acks[exp_g]));
      lb_wready = 1'b1;
      #1;
      chk("rr_m_wready", 64'(m_wready), 64'(2'b01 << exp_g));
      cyc();
      lb_wready = 1'b0;
      acks[exp_g]++;
      if (exp_g == 0) m_waddr[15:0]  = 16'h0100 + 16'(acks[0]);
      else            m_waddr[31:16] = 16'h0200 + 16'(acks[1]);
      if (acks[exp_g] == 4) m_wen[exp_g] = 1'b0;
      #1;
      chk("rr_idle_gap", 64'(busy), 64'd0);
    end
    chk("rr_acks_m0", 64'(acks[0]), 64'd4);
    chk("rr_acks_m1", 64'(acks[1]), 64'd4);

    // Master 0 requests write and read together: write first, then read.
    m_wen = 2'b01; m_waddr[15:0] = 16'h0080; m_wdata[31:0] = 32'h0000A5A5;
    m_ren = 2'b01; m_raddr[15:0] = 16'h0084;
    cyc(); #1;
    chk("wr1st_lb_wen", 64'(lb_wen), 64'd1);
    chk("wr1st_lb_ren", 64'(lb_ren), 64'd0);
    chk("wr1st_lb_waddr", 64'(lb_waddr), 64'h80);
    lb_rvalid = 1'b1;
    #1;
    chk("wr_ignores_rvalid", 64'(m_rvalid), 64'd0);
    lb_rvalid = 1'b0; lb_wready = 1'b1;
    #1;
    chk("wr1st_m_wready", 64'(m_wready), 64'b01);
    cyc();
    m_wen = '0; lb_wready = 1'b0;
    cyc(); #1;
    chk("rd2nd_lb_ren", 64'(lb_ren), 64'd1);
    chk("rd2nd_lb_raddr", 64'(lb_raddr), 64'h84);
    chk("rd2nd_grant", 64'(grant), 64'd0);
    m_ren = '0;
    cyc(); #1;
    chk("rd_req_drop_held", 64'(lb_ren), 64'd1);
    lb_rvalid = 1'b1; lb_rdata = 32'hCAFE0001;
    #1;
    chk("rd_req_drop_ack", 64'(m_rvalid), 64'b01);
    chk("rd_req_drop_data", 64'(m_rdata), 64'hCAFE0001);
    cyc();
    lb_rvalid = 1'b0;

    // Reset in the middle of a read from master 1.
    m_ren = 2'b10; m_raddr[31:16] = 16'h0090;
    cyc(); #1;
    chk("rst_rd_lb_ren_before", 64'(lb_ren), 64'd1);
    rst = 1'b0; m_ren = '0; lb_rvalid = 1'b1;
    #1;
    chk("rst_rd_lb_ren", 64'(lb_ren), 64'd0);
    chk("rst_rd_no_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_rd_grant", 64'(grant), 64'd0);
    chk("rst_rd_busy", 64'(busy), 64'd0);
    cyc();
    rst = 1'b1; lb_rvalid = 1'b0;
    m_wen = 2'b11; m_waddr[15:0] = 16'h0010; m_waddr[31:16] = 16'h0020;
    cyc(); #1;
    chk("post_rst_grant", 64'(grant), 64'd0);
    chk("post_rst_waddr", 64'(lb_waddr), 64'h10);
    lb_wready = 1'b1;
    cyc();
    m_wen = '0; lb_wready = 1'b0;
    #1;
    chk("post_rst_tmo_err", 64'(tmo_err), 64'd0);

`ifdef LB_ARB_TIMEOUT_EN
    // Slave never answers: error completion on the 256th RD cycle.
    m_ren = 2'b01; m_raddr[15:0] = 16'h00F0;
    cyc();
    m_ren = '0;
    cyc(254); #1;
    chk("tmo_not_yet", 64'(tmo_err), 64'd0);
    cyc(); #1;
    chk("tmo_err", 64'(tmo_err), 64'd1);
    chk("tmo_m_rvalid", 64'(m_rvalid), 64'b01);
    chk("tmo_m_rdata", 64'(m_rdata), 64'hDEADBEEF);
    cyc(); #1;
    chk("tmo_lb_ren_drop", 64'(lb_ren), 64'd0);
    // Response in the expiry cycle completes normally.
    m_ren = 2'b01;
    cyc();
    m_ren = '0;
    cyc(255);
    lb_rvalid = 1'b1; lb_rdata = 32'h00001234;
    #1;
    chk("tmo_race_no_err", 64'(tmo_err), 64'd0);
    chk("tmo_race_rdata", 64'(m_rdata), 64'h1234);
    cyc();
    lb_rvalid = 1'b0;
`endif

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
